conv_mac_array: RTL and testbench

CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

---
 rtl/conv_mac_array.sv | 175 +++++++++++++++++
 tb/tb_conv_mac_array.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_array.sv
// Parallel multiply-accumulate array: CPF-channel beats into KPF lanes, with requant and an output FIFO.
// Optional macro CONV_MAC_SAT_EN selects saturation instead of truncation of the requant value.
module conv_mac_array #(
    parameter int CPF          = 4,
    parameter int KPF          = 8,
    parameter int DIN_DW       = 16,
    parameter int WW           = 16,
    parameter int BIAS_DW      = 8,
    parameter int DOUT_DW      = 16,
    parameter int ACC_WIDTH    = 40,
    parameter int SHIFT        = 9,
    parameter int BIAS_SHIFT   = 8,
    parameter int RELU         = 0,
    parameter int FIFO_DEPTH   = 8,
    parameter int OUT_PER_BLOB = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        op_din_en,
    input  logic                        op_din_eop,
    input  logic [CPF*DIN_DW-1:0]       op_din,
    input  logic [KPF*CPF*WW-1:0]       op_weight,
    input  logic [KPF*BIAS_DW-1:0]      op_bias,
    output logic                        op_din_rdy,
    output logic [KPF*DOUT_DW-1:0]      blob_dout,
    output logic                        blob_dout_en,
    input  logic                        blob_dout_rdy,
    output logic                        blob_dout_eop
);

    localparam int PW = DIN_DW + WW;
    localparam int SW = PW + $clog2(CPF) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OUT_PER_BLOB + 1);
    localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (SHIFT - 1);
`ifdef CONV_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'((64'sd1 <<< (DOUT_DW - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] QMIN = -QMAX - ACC_WIDTH'(1);
`endif

    logic                        accept;
    logic signed [SW-1:0]        beat_sum [KPF];
    logic                        s1_v, s1_eop;
    logic signed [SW-1:0]        s1_sum [KPF];
    logic [KPF*BIAS_DW-1:0]      s1_bias;
    logic signed [ACC_WIDTH-1:0] acc [KPF];
    logic signed [ACC_WIDTH-1:0] acc_next [KPF];
    logic signed [ACC_WIDTH-1:0] bias_al [KPF];
    logic signed [ACC_WIDTH-1:0] fin [KPF];
    logic                        s2_v;
    logic [KPF*DOUT_DW-1:0]      q_next;
    logic [KPF*DOUT_DW-1:0]      s3_q;
    logic                        s3_v;
    logic [KPF*DOUT_DW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [AW:0]                 count;
    logic [1:0]                  inflight;
    logic [CW-1:0]               out_cnt;
    logic                        push, pop;

    assign accept = op_din_en & op_din_rdy;

    always_comb begin
        for (int unsigned k = 0; k < KPF; k++) begin
            beat_sum[k] = '0;
            for (int unsigned c = 0; c < CPF; c++) begin
                beat_sum[k] = beat_sum[k] + SW'(PW'($signed(op_din[c*DIN_DW +: DIN_DW]))
                                              * PW'($signed(op_weight[(k*CPF+c)*WW +: WW])));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_eop  <= 1'b0;
            s1_bias <= '0;
            for (int unsigned k = 0; k < KPF; k++) s1_sum[k] <= '0;
        end else begin
            s1_v   <= accept;
            s1_eop <= accept & op_din_eop;
            if (accept) begin
                for (int unsigned k = 0; k < KPF; k++) s1_sum[k] <= beat_sum[k];
                if (op_din_eop) s1_bias <= op_bias;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < KPF; k++) begin
            acc_next[k] = acc[k] + ACC_WIDTH'(s1_sum[k]);
            bias_al[k]  = ACC_WIDTH'($signed(s1_bias[k*BIAS_DW +: BIAS_DW])) <<< BIAS_SHIFT;
        end
    end

    // The eop beat folds into the final sum and clears acc in the same edge, so no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v <= 1'b0;
            for (int unsigned k = 0; k < KPF; k++) begin
                acc[k] <= '0;
                fin[k] <= '0;
            end
        end else begin
            s2_v <= s1_v & s1_eop;
            if (s1_v) begin
                for (int unsigned k = 0; k < KPF; k++) begin
                    if (s1_eop) begin
                        fin[k] <= acc_next[k] + bias_al[k];
                        acc[k] <= '0;
                    end else begin
                        acc[k] <= acc_next[k];
                    end
                end
            end
        end
    end

    always_comb begin
        logic signed [ACC_WIDTH-1:0] rq;
        q_next = '0;
        for (int unsigned k = 0; k < KPF; k++) begin
            rq = (fin[k] + RND) >>> SHIFT;
            if (RELU != 0 && rq < 0) rq = '0;
`ifdef CONV_MAC_SAT_EN
            if (rq > QMAX)      rq = QMAX;
            else if (rq < QMIN) rq = QMIN;
`endif
            q_next[k*DOUT_DW +: DOUT_DW] = rq[DOUT_DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v <= 1'b0;
            s3_q <= '0;
        end else begin
            s3_v <= s2_v;
            s3_q <= q_next;
        end
    end

    assign push     = s3_v;
    assign pop      = blob_dout_en & blob_dout_rdy;
    assign inflight = {1'b0, s1_v & s1_eop} + {1'b0, s2_v} + {1'b0, s3_v};

    // Credit check reserves FIFO slots for every eop still in the pipe, so push never overflows.
    assign op_din_rdy = !rst && ((AW+2)'(count) + (AW+2)'(inflight) < (AW+2)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_cnt <= (out_cnt == CW'(OUT_PER_BLOB - 1)) ? '0 : out_cnt + 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign blob_dout_en  = (count != '0);
    assign blob_dout     = blob_dout_en ? mem[rd_ptr] : '0;
    assign blob_dout_eop = blob_dout_en && (out_cnt == CW'(OUT_PER_BLOB - 1));

endmodule

// File: tb/tb_conv_mac_array.sv
// Self-checking bench for conv_mac_array: two instances (default and RELU/short blob) share stimulus.
module tb_conv_mac_array;

    localparam int CPF = 4;
    localparam int KPF = 8;
    localparam int DW  = KPF * 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_din_en = 1'b0, op_din_eop = 1'b0;
    logic [CPF*16-1:0]     op_din = '0;
    logic [KPF*CPF*16-1:0] op_weight = '0;
    logic [KPF*8-1:0]      op_bias = '0;
    logic blob_dout_rdy = 1'b1;
    logic rdy_a, en_a, eop_a, rdy_b, en_b, eop_b;
    logic [DW-1:0] dout_a, dout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_mac_array u_a (
        .clk(clk), .rst(rst), .op_din_en(op_din_en), .op_din_eop(op_din_eop),
        .op_din(op_din), .op_weight(op_weight), .op_bias(op_bias), .op_din_rdy(rdy_a),
        .blob_dout(dout_a), .blob_dout_en(en_a), .blob_dout_rdy(blob_dout_rdy),
        .blob_dout_eop(eop_a)
    );

    conv_mac_array #(.RELU(1), .OUT_PER_BLOB(3)) u_b (
        .clk(clk), .rst(rst), .op_din_en(op_din_en), .op_din_eop(op_din_eop),
        .op_din(op_din), .op_weight(op_weight), .op_bias(op_bias), .op_din_rdy(rdy_b),
        .blob_dout(dout_b), .blob_dout_en(en_b), .blob_dout_rdy(blob_dout_rdy),
        .blob_dout_eop(eop_b)
    );

    // Reference model state
    longint macc [KPF];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    int pc_a = 0, pc_b = 0, pidx_b = 0;
    logic [15:0] hist_b = '0;
    logic [DW-1:0] last_a = '0;
    bit rnd_rdy = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    function automatic logic [15:0] requant(input longint f, input bit relu);
        longint v;
        v = wrap40(wrap40(f) + 256) >>> 9;
        if (relu && v < 0) v = 0;
`ifdef CONV_MAC_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    task automatic model_accept(input logic [CPF*16-1:0] d, input logic [KPF*CPF*16-1:0] w,
                                input logic [KPF*8-1:0] b, input logic eop);
        logic [DW-1:0] ra, rb;
        longint f;
        ra = '0; rb = '0;
        for (int k = 0; k < KPF; k++) begin
            for (int c = 0; c < CPF; c++)
                macc[k] += longint'($signed(d[c*16 +: 16])) * longint'($signed(w[(k*CPF+c)*16 +: 16]));
            macc[k] = wrap40(macc[k]);
            if (eop) begin
                f = macc[k] + (longint'($signed(b[k*8 +: 8])) <<< 8);
                ra[k*16 +: 16] = requant(f, 1'b0);
                rb[k*16 +: 16] = requant(f, 1'b1);
                macc[k] = 0;
            end
        end
        if (eop) begin
            qa.push_back(ra);
            qb.push_back(rb);
        end
    endtask

    // Scoreboard: compare at negedge whenever a pop will happen on the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rdy_match", rdy_b, rdy_a);
            if (en_a && blob_dout_rdy) begin
                if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
                else begin
                    chk("a_dout", dout_a, qa.pop_front());
                    chk("a_eop", eop_a, (pc_a == 1023));
                    pc_a = (pc_a == 1023) ? 0 : pc_a + 1;
                    last_a = dout_a;
                end
            end
            if (en_b && blob_dout_rdy) begin
                if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
                else begin
                    chk("b_dout", dout_b, qb.pop_front());
                    chk("b_eop", eop_b, (pc_b == 2));
                    pc_b = (pc_b == 2) ? 0 : pc_b + 1;
                    if (pidx_b < 16) hist_b[pidx_b] = eop_b;
                    pidx_b++;
                end
            end
        end
    end

    always @(posedge clk) if (rnd_rdy) #2 blob_dout_rdy = 1'($urandom_range(0, 1));

    // Called at a negedge; holds the beat until accepted or max_wait cycles pass.
    task automatic offer(input logic [CPF*16-1:0] d, input logic [KPF*CPF*16-1:0] w,
                         input logic [KPF*8-1:0] b, input logic eop, input int max_wait,
                         output bit ok);
        ok = 0;
        op_din = d; op_weight = w; op_bias = b; op_din_eop = eop; op_din_en = 1'b1;
        for (int i = 0; i < max_wait && !ok; i++) begin
            if (rdy_a) begin
                model_accept(d, w, b, eop);
                ok = 1;
            end
            @(negedge clk);
        end
        op_din_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < KPF; k++) macc[k] = 0;
        qa.delete(); qb.delete();
        pc_a = 0; pc_b = 0; pidx_b = 0; hist_b = '0;
        @(negedge clk);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_en", en_a, 0);
        chk("rst_eop", eop_a | eop_b, 0);
        chk("rst_dout", (dout_a != '0) || (dout_b != '0), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", rdy_a, 1);
        chk("post_rst_en", en_a, 0);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        chk("drain_left", qa.size() + qb.size(), 0);
    endtask

    function automatic logic [CPF*16-1:0] mkd(input int v);
        logic [CPF*16-1:0] d;
        for (int c = 0; c < CPF; c++) d[c*16 +: 16] = 16'(v);
        return d;
    endfunction

    function automatic logic [KPF*CPF*16-1:0] mkw(input int w0);
        logic [KPF*CPF*16-1:0] w;
        for (int k = 0; k < KPF; k++)
            for (int c = 0; c < CPF; c++)
                w[(k*CPF+c)*16 +: 16] = (k == 0) ? 16'(w0) : 16'(k*1000 - 3000 + c);
        return w;
    endfunction

    function automatic logic [KPF*8-1:0] mkb(input int b0);
        logic [KPF*8-1:0] b;
        for (int k = 0; k < KPF; k++) b[k*8 +: 8] = (k < 2) ? 8'(b0) : 8'(k);
        return b;
    endfunction

    typedef struct {
        int din; int w; int b; int beats; int exp_sat; int exp_trunc;
    } vec_t;

    initial begin
        vec_t tbl [7];
        bit ok;
        int acc_cnt;
        logic signed [15:0] l0;

        tbl[0] = '{256,    128,    0,  1, 256,    256};
        tbl[1] = '{256,    128,    1,  3, 769,    769};
        tbl[2] = '{256,    -128,   0,  1, -256,   -256};
        tbl[3] = '{32767,  32767,  0,  1, 32767,  -512};
        tbl[4] = '{32767,  -32767, 0,  1, -32768, 512};
        tbl[5] = '{100,    3,      -5, 2, 2,      2};
        tbl[6] = '{0,      0,      127,1, 64,     64};

        for (int k = 0; k < KPF; k++) macc[k] = 0;
        repeat (2) @(negedge clk);
        chk("init_rdy", rdy_a, 0);
        chk("init_en", en_a, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_rdy", rdy_a, 1);

        // Latency: single eop beat, output visible four cycles after acceptance.
        offer(mkd(256), mkw(128), '0, 1'b1, 4, ok);
        chk("lat_accept", ok, 1);
        chk("lat_en_t1", en_a, 0);
        @(negedge clk); chk("lat_en_t2", en_a, 0);
        @(negedge clk); chk("lat_en_t3", en_a, 0);
        @(negedge clk); chk("lat_en_t4", en_a, 1);
        chk("lat_lane0", dout_a[15:0], 256);
        chk("lat_others", dout_a[DW-1:16] == '0 ? 0 : 1, 1);
        drain(10);

        // Table vectors: back-to-back beats, lane0 value checked against hand constants.
        foreach (tbl[i]) begin
            for (int bt = 0; bt < tbl[i].beats; bt++) begin
                offer(mkd(tbl[i].din), mkw(tbl[i].w), mkb(tbl[i].b),
                      (bt == tbl[i].beats - 1), 10, ok);
                chk("tbl_accept", ok, 1);
            end
            drain(20);
            l0 = last_a[15:0];
`ifdef CONV_MAC_SAT_EN
            chk("tbl_lane0", l0, tbl[i].exp_sat);
`else
            chk("tbl_lane0", l0, tbl[i].exp_trunc);
`endif
        end

        // Backpressure: consumer stalled, 12 eops offered, exactly 8 taken.
        @(posedge clk); #2 blob_dout_rdy = 1'b0;
        @(negedge clk);
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            offer(mkd(i + 1), mkw(50 + i), mkb(i), 1'b1, 2, ok);
            if (ok) acc_cnt++;
        end
        chk("bp_accepted", acc_cnt, 8);
        chk("bp_rdy_low", rdy_a, 0);
        chk("bp_en", en_a, 1);
        @(posedge clk); #2 blob_dout_rdy = 1'b1;
        drain(20);
        @(negedge clk);
        chk("bp_rdy_back", rdy_a, 1);

        // Blob eop on instance b (OUT_PER_BLOB=3) after a fresh reset.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            offer(mkd(10 + i), mkw(7), mkb(0), 1'b1, 10, ok);
            chk("blob_accept", ok, 1);
        end
        drain(20);
        chk("blob_eop_hist", hist_b[6:0], 7'b0100100);

        // Reset mid-sum discards the partial result.
        offer(mkd(256), mkw(128), '0, 1'b0, 4, ok);
        chk("mid_accept", ok, 1);
        do_reset();
        repeat (8) @(negedge clk);
        chk("mid_no_out", en_a, 0);
        offer(mkd(256), mkw(128), '0, 1'b0, 4, ok);
        offer(mkd(256), mkw(128), '0, 1'b1, 4, ok);
        drain(20);
        l0 = last_a[15:0];
        chk("mid_clean_sum", l0, 512);

        // Random sums under random consumer stalls.
        rnd_rdy = 1;
        for (int s = 0; s < 30; s++) begin
            int nb;
            logic [CPF*16-1:0] d;
            logic [KPF*CPF*16-1:0] w;
            logic [KPF*8-1:0] b;
            nb = $urandom_range(1, 4);
            for (int bt = 0; bt < nb; bt++) begin
                for (int c = 0; c < CPF; c++) d[c*16 +: 16] = 16'($urandom);
                for (int j = 0; j < KPF*CPF; j++) w[j*16 +: 16] = 16'($urandom);
                for (int k = 0; k < KPF; k++) b[k*8 +: 8] = 8'($urandom);
                offer(d, w, b, (bt == nb - 1), 60, ok);
                chk("rnd_accept", ok, 1);
            end
        end
        rnd_rdy = 0;
        @(posedge clk); #3 blob_dout_rdy = 1'b1;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
